display_poll_arbiter: RTL and testbench
=======================================

Name: display_poll_arbiter

Overview:
- Round-robin poller that shares the 4-digit seven-segment display path among NUM_SRC requesters.
- Each requester offers a 16-bit value with a req/ack handshake.
- The arbiter grants one source, latches its value onto disp_data, and holds it for DWELL_CYCLES before polling again.
- disp_data feeds the seven-segment driver's 16-bit datain bus directly.

Parameters:
- NUM_SRC, 4: number of requesters; must be at least 2.
- DW, 16: display word width; fixed at 4 hex digits.
- DWELL_CYCLES, 50000000: clk cycles a granted value is held before the next poll; must be at least 1.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_SRC  per-source request; level-held until acked.
- data_in  in  NUM_SRC*DW  source i drives bits [i*DW +: DW]; must be stable while req[i] is high.
- ack  out  NUM_SRC  one-hot, one-cycle grant/consume pulse.
- disp_data  out  DW  value presented to the seven-segment driver.
- disp_src  out  clog2(NUM_SRC)  index of the source currently displayed.
- disp_valid  out  1  high once any value has been latched since reset.
- busy  out  1  high in GRANT and DWELL.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ptr=0, ack=0, disp_data=0, disp_src=0, disp_valid=0, busy=0, dwell counter=0.
- FSM states are IDLE, GRANT and DWELL.
- IDLE:
  - Evaluate req combinationally from ptr upward with wrap-around; the first set bit wins.
  - On the next edge: go to GRANT, register grant index g, load disp_data <= data_in[g], disp_src <= g, disp_valid <= 1.
  - If no req is set: stay in IDLE, outputs hold their last value.
- GRANT (exactly 1 cycle):
  - ack[g]=1 (registered, so it is high during the GRANT cycle only), busy=1.
  - Load counter with DWELL_CYCLES-1, then go to DWELL.
- DWELL:
  - busy=1, count down to 0; the cycle in which the counter reads 0 is the last DWELL cycle.
  - On that cycle's edge: ptr <= (g+1) mod NUM_SRC, go to IDLE.
- Latency: req high in an IDLE cycle leads to disp_data updated and ack high in the next cycle.
- Grant-to-grant minimum spacing is DWELL_CYCLES+2 cycles.
- The display never changes during DWELL; req changes during GRANT/DWELL are ignored until IDLE.
- A source whose req is still high after its ack is a new request; it competes again only after all other requesting sources have been served (fairness from the ptr advance).
- req dropped before grant means no ack and no capture for that source.
- Pointer wrap: g=NUM_SRC-1 gives ptr=0.
- DWELL_CYCLES=1: DWELL lasts exactly 1 cycle.
- Reset asserted mid-GRANT/DWELL: immediate return to reset values; any pending ack is dropped; the source keeps req high and is re-served after release.
- Counter width is clog2(DWELL_CYCLES); it never wraps.

Optional Feature:
- Macro: DISP_SRC_TAG_EN.
- Defined: disp_data[DW-1:DW-4] is replaced with disp_src zero-extended to 4 bits, so the leftmost digit shows the source number; the lower 12 bits come from data_in.
- Undefined: all 16 bits come from data_in unmodified.
- ack, disp_src and timing are identical in both builds.

Decomposition:
- Package disp_poll_pkg holds:
  - state enum {IDLE, GRANT, DWELL};
  - DISP_DW=16 localparam;
  - a function computing the source index width.
- One sub-module, rr_pick: combinational rotate-priority pick.
  - Inputs: req, ptr.
  - Outputs: any, idx.
- FSM, counter and output registers stay in the top level.

Test Plan:
- Reset: set NUM_SRC=4, DWELL_CYCLES=4; assert rst_n=0 mid-DWELL -> ack=0, disp_data=0x0000, disp_valid=0 with no clock edge needed.
- Single source: req=0001, data_in[0]=0x1234 -> ack[0] high exactly 1 cycle after req seen; disp_data=0x1234, disp_src=0; next grant no sooner than 6 cycles later.
- All requesting: req=1111 held -> grant order 0,1,2,3,0, each ack spaced exactly 6 cycles apart.
- Wrap/skip: ptr=3 after serving source 2, req=0101 -> source 0 granted, then source 2.
- Change during DWELL: data_in[1] changes 0xAAAA to 0x5555 after ack -> disp_data stays 0xAAAA until the next grant.
- DISP_SRC_TAG_EN build: source 2 offers 0xBEEF -> disp_data=0x2EEF; without the macro -> 0xBEEF.

Source files
------------

// File: rtl/disp_poll_pkg.sv
`default_nettype none
// ============================================================================
// Module  : disp_poll_pkg
// Purpose : Shared types and sizing helpers for the display poll arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package disp_poll_pkg;

  localparam int DISP_DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DWELL = 2'd2
  } state_t;

  // Index width for a requester count; never narrower than one bit.
  function automatic int src_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Dwell counter width; must hold DWELL_CYCLES-1, and at least one bit.
  function automatic int dwell_cnt_w(input int d);
    return (d <= 2) ? 1 : $clog2(d);
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_poll_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational rotate-priority pick: first set req at or above ptr,
//           wrapping around.
// Rev     : 1.0  initial release
// ============================================================================
module rr_pick
  import disp_poll_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IW      = src_idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               any,
  output logic [IW-1:0]      idx
);

  int unsigned   w_pos;
  logic [IW-1:0] w_cand;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    w_pos  = 0;
    w_cand = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_pos = 32'(ptr) + 32'(k);
      if (w_pos >= 32'(NUM_SRC)) begin
        w_pos = w_pos - 32'(NUM_SRC);
      end
      w_cand = IW'(w_pos);
      if (req[w_cand]) begin
        any = 1'b1;
        idx = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_poll_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : display_poll_arbiter
// Purpose : Round-robin poller sharing the 4-digit seven-segment display among
//           NUM_SRC requesters; optional macro DISP_SRC_TAG_EN puts the source
//           number in the leftmost digit.
// Rev     : 1.0  initial release
// ============================================================================
module display_poll_arbiter
  import disp_poll_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DW           = DISP_DW,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            req,
  input  logic [NUM_SRC*DW-1:0]         data_in,
  output logic [NUM_SRC-1:0]            ack,
  output logic [DW-1:0]                 disp_data,
  output logic [src_idx_w(NUM_SRC)-1:0] disp_src,
  output logic                          disp_valid,
  output logic                          busy
);

  localparam int IW = src_idx_w(NUM_SRC);
  localparam int CW = dwell_cnt_w(DWELL_CYCLES);

  localparam logic [CW-1:0] C_DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] C_LAST_SRC   = IW'(NUM_SRC - 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [NUM_SRC-1:0]   ack_q, ack_d;
  logic [DW-1:0]        disp_data_q, disp_data_d;
  logic [IW-1:0]        disp_src_q, disp_src_d;
  logic                 disp_valid_q, disp_valid_d;
  logic                 busy_q, busy_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 w_pick_any;
  logic [IW-1:0]        w_pick_idx;
  logic [DW-1:0]        w_sel_word;
  logic [DW-1:0]        w_cap_word;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IW      (IW)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .any (w_pick_any),
    .idx (w_pick_idx)
  );

  assign w_sel_word = data_in[w_pick_idx*DW +: DW];

`ifdef DISP_SRC_TAG_EN
  assign w_cap_word = {4'(w_pick_idx), w_sel_word[DW-5:0]};
`else
  assign w_cap_word = w_sel_word;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ack_d        = '0;
    disp_data_d  = disp_data_q;
    disp_src_d   = disp_src_q;
    disp_valid_d = disp_valid_q;
    busy_d       = busy_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (w_pick_any) begin
          state_d             = GRANT;
          ack_d[w_pick_idx]   = 1'b1;
          disp_data_d         = w_cap_word;
          disp_src_d          = w_pick_idx;
          disp_valid_d        = 1'b1;
          busy_d              = 1'b1;
        end
      end

      GRANT: begin
        cnt_d   = C_DWELL_LOAD;
        state_d = DWELL;
      end

      DWELL: begin
        // disp_src_q still holds the granted index, so it seeds the next poll.
        if (cnt_q == '0) begin
          ptr_d   = (disp_src_q == C_LAST_SRC) ? '0 : disp_src_q + 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      ack_q        <= '0;
      disp_data_q  <= '0;
      disp_src_q   <= '0;
      disp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ack_q        <= ack_d;
      disp_data_q  <= disp_data_d;
      disp_src_q   <= disp_src_d;
      disp_valid_q <= disp_valid_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ack        = ack_q;
  assign disp_data  = disp_data_q;
  assign disp_src   = disp_src_q;
  assign disp_valid = disp_valid_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_display_poll_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_display_poll_arbiter
// Purpose : Scoreboard bench for display_poll_arbiter (NUM_SRC=4, DWELL=4).
// Rev     : 1.0  initial release
// ============================================================================
module tb_display_poll_arbiter;
  import disp_poll_pkg::*;

  localparam int NS    = 4;
  localparam int DW    = 16;
  localparam int DWELL = 4;
  localparam int GAP   = DWELL + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [NS-1:0]    req = '0;
  logic [NS*DW-1:0] data_in = '0;
  logic [NS-1:0]    ack;
  logic [DW-1:0]    disp_data;
  logic [1:0]       disp_src;
  logic             disp_valid;
  logic             busy;

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    int            gap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_ack_cyc = 0;

  display_poll_arbiter #(
    .NUM_SRC      (NS),
    .DW           (DW),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data_in    (data_in),
    .ack        (ack),
    .disp_data  (disp_data),
    .disp_src   (disp_src),
    .disp_valid (disp_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] exp_data(input int s, input logic [DW-1:0] v);
    logic [3:0] t;
    t = s[3:0];
`ifdef DISP_SRC_TAG_EN
    return {t, v[DW-5:0]};
`else
    return (t == t) ? v : v;
`endif
  endfunction

  task automatic expect_grant(input int s, input logic [DW-1:0] v, input int g);
    exp_t e;
    e.src  = s;
    e.data = v;
    e.gap  = g;
    sb.push_back(e);
  endtask

  task automatic set_word(input int s, input logic [DW-1:0] v);
    data_in[s*DW +: DW] = v;
  endtask

  task automatic wait_sb_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d grants still outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Scoreboard: every ack pulse pops one expected grant.
  always @(posedge clk) begin
    exp_t          e;
    logic [NS-1:0] ea;
    #1;
    if (rst_n === 1'b1 && ack !== '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack=%b, required no grant", ack);
      end else begin
        e = sb.pop_front();
        ea = '0;
        ea[e.src] = 1'b1;
        checks++;
        if (ack !== ea) begin
          errors++;
          $display("FAIL grant_ack: ack=%b, required %b", ack, ea);
        end
        checks++;
        if (disp_data !== exp_data(e.src, e.data)) begin
          errors++;
          $display("FAIL grant_data: disp_data=%h, required %h", disp_data, exp_data(e.src, e.data));
        end
        checks++;
        if (disp_src !== e.src[1:0]) begin
          errors++;
          $display("FAIL grant_src: disp_src=%0d, required %0d", disp_src, e.src);
        end
        checks++;
        if (disp_valid !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL grant_flags: valid=%b busy=%b, required 1 1", disp_valid, busy);
        end
        if (e.gap > 0) begin
          checks++;
          if (cyc - last_ack_cyc !== e.gap) begin
            errors++;
            $display("FAIL grant_gap: spacing=%0d, required %0d", cyc - last_ack_cyc, e.gap);
          end
        end
      end
      last_ack_cyc = cyc;
    end
  end

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 4'b0000 || disp_data !== 16'h0000 || disp_src !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b data=%h src=%0d, required 0000 0000 0", ack, disp_data, disp_src);
    end
    checks++;
    if (disp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b busy=%b, required 0 0", disp_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_word(0, 16'h1234);
    expect_grant(0, 16'h1234, 0);
    req = 4'b0001;
    wait_sb_empty("reset_first_grant");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 4'b0000 || disp_data !== 16'h0000 || disp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_dwell: ack=%b data=%h valid=%b, required 0000 0000 0", ack, disp_data, disp_valid);
    end
    checks++;
    if (busy !== 1'b0 || disp_src !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_dwell_busy: busy=%b src=%0d, required 0 0", busy, disp_src);
    end
    expect_grant(0, 16'h1234, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sb_empty("reset_reserve");
    req = '0;
    wait_idle();
  endtask

  task automatic test_single();
    set_word(0, 16'h1234);
    expect_grant(0, 16'h1234, 0);
    expect_grant(0, 16'h1234, GAP);
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0001 || disp_data !== exp_data(0, 16'h1234)) begin
      errors++;
      $display("FAIL single_latency: ack=%b data=%h, required 0001 %h", ack, disp_data, exp_data(0, 16'h1234));
    end
    wait_sb_empty("single");
    req = '0;
    wait_idle();
  endtask

  task automatic test_all_requesting();
    do_reset();
    for (int i = 0; i < NS; i++) set_word(i, 16'(16'h1111 * (i + 1)));
    expect_grant(0, 16'h1111, 0);
    expect_grant(1, 16'h2222, GAP);
    expect_grant(2, 16'h3333, GAP);
    expect_grant(3, 16'h4444, GAP);
    expect_grant(0, 16'h1111, GAP);
    req = 4'b1111;
    wait_sb_empty("all_requesting");
    req = '0;
    wait_idle();
  endtask

  task automatic test_wrap_skip();
    do_reset();
    set_word(2, 16'h2020);
    expect_grant(2, 16'h2020, 0);
    req = 4'b0100;
    wait_sb_empty("wrap_first");
    set_word(0, 16'h0A0A);
    set_word(2, 16'h2B2B);
    expect_grant(0, 16'h0A0A, GAP);
    expect_grant(2, 16'h2B2B, GAP);
    req = 4'b0101;
    wait_sb_empty("wrap_skip");
    req = '0;
    wait_idle();
  endtask

  task automatic test_dwell_change();
    int n;
    do_reset();
    set_word(1, 16'hAAAA);
    expect_grant(1, 16'hAAAA, 0);
    expect_grant(1, 16'h5555, GAP);
    req = 4'b0010;
    n = 0;
    while (sb.size() != 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    set_word(1, 16'h5555);
    repeat (DWELL + 1) begin
      @(negedge clk);
      checks++;
      if (disp_data !== exp_data(1, 16'hAAAA)) begin
        errors++;
        $display("FAIL dwell_hold: disp_data=%h, required %h", disp_data, exp_data(1, 16'hAAAA));
      end
    end
    wait_sb_empty("dwell_change");
    req = '0;
    wait_idle();
  endtask

  task automatic test_tag();
    logic [DW-1:0] want;
`ifdef DISP_SRC_TAG_EN
    want = 16'h2EEF;
`else
    want = 16'hBEEF;
`endif
    do_reset();
    set_word(2, 16'hBEEF);
    expect_grant(2, 16'hBEEF, 0);
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (disp_data !== want) begin
      errors++;
      $display("FAIL tag_word: disp_data=%h, required %h", disp_data, want);
    end
    wait_sb_empty("tag");
    req = '0;
    wait_idle();
  endtask

  task automatic test_req_drop();
    do_reset();
    set_word(0, 16'h0101);
    set_word(3, 16'h3333);
    expect_grant(0, 16'h0101, 0);
    req = 4'b0001;
    wait_sb_empty("drop_first");
    req = 4'b1000;
    repeat (2) @(negedge clk);
    req = '0;
    repeat (12) @(negedge clk);
    checks++;
    if (disp_src !== 2'd0 || disp_data !== exp_data(0, 16'h0101) || busy !== 1'b0) begin
      errors++;
      $display("FAIL req_drop: src=%0d data=%h busy=%b, required 0 %h 0", disp_src, disp_data, busy, exp_data(0, 16'h0101));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_requesting();
    test_wrap_skip();
    test_dwell_change();
    test_tag();
    test_req_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
